// File: rtl/slow_tick_timer_if.sv
// Control/status bundle between slow_tick_timer and the logic that drives it.
// master = controller side (drives start/pause/clear/load_val), slave = timer side.
interface slow_tick_timer_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             pause;
    logic             clear;
    logic [CNT_W-1:0] load_val;
    logic             tick;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;
    logic             alarm;

    modport master (
        output start, pause, clear, load_val,
        input  tick, count, busy, done, alarm
    );

    modport slave (
        input  start, pause, clear, load_val,
        output tick, count, busy, done, alarm
    );
endinterface

// File: rtl/slow_tick_timer.sv
// Synchronises a divided slow clock, turns each rising edge into a one-cycle tick and runs a
// start/pause/clear countdown with expiry pulse and blinking alarm. Option macro: AUTO_RELOAD_EN.
module slow_tick_timer #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              slow_clk,
    slow_tick_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
            $error("slow_tick_timer: SYNC_STAGES must be in 2..4");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_hist_q;
    logic                   tick_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d, done_req;
    logic             alarm_q, alarm_d;

    // Only sync_q[0] may go metastable; everything downstream sees the settled last stage.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q      <= '0;
            edge_hist_q <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], slow_clk};
            edge_hist_q <= sync_q[SYNC_STAGES-1];
            tick_q      <= sync_q[SYNC_STAGES-1] & ~edge_hist_q;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            alarm_q <= alarm_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no branch can infer a latch.
        state_d  = state_q;
        count_d  = count_q;
        alarm_d  = alarm_q;
        done_req = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!bus.clear && bus.start) begin
                    if (bus.load_val != '0) begin
                        count_d = bus.load_val;
                        state_d = RUN;
                    end else begin
                        count_d  = '0;
                        state_d  = DONE;
                        done_req = 1'b1;
                    end
                end
            end

            RUN: begin
                if (bus.clear) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (bus.pause) begin
                    state_d = PAUSED;
                end else if (tick_q) begin
                    if (count_q > CNT_W'(1)) begin
                        count_d = count_q - CNT_W'(1);
                    end else begin
                        done_req = 1'b1;
`ifdef AUTO_RELOAD_EN
                        // A zero reload value cannot keep counting, so it parks in DONE.
                        if (bus.load_val != '0) begin
                            count_d = bus.load_val;
                        end else begin
                            count_d = '0;
                            state_d = DONE;
                        end
`else
                        count_d = '0;
                        state_d = DONE;
`endif
                    end
                end
            end

            PAUSED: begin
                if (bus.clear) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (!bus.pause && bus.start) begin
                    state_d = RUN;
                end
            end

            DONE: begin
                if (bus.clear) begin
                    state_d = IDLE;
                    count_d = '0;
                    alarm_d = 1'b0;
                end else if (bus.start) begin
                    alarm_d = 1'b0;
                    if (bus.load_val != '0) begin
                        count_d = bus.load_val;
                        state_d = RUN;
                    end else begin
                        count_d  = '0;
                        done_req = 1'b1;
                    end
                end else if (tick_q) begin
                    alarm_d = ~alarm_q;
                end
            end

            default: begin
                state_d = IDLE;
                count_d = '0;
                alarm_d = 1'b0;
            end
        endcase
    end

    // busy is derived from the next state so it changes on the same edge as the FSM.
    assign busy_d = (state_d == RUN) || (state_d == PAUSED);
    // A start held high in DONE with load_val == 0 would otherwise re-fire every cycle.
    assign done_d = done_req & ~done_q;

    assign bus.tick  = tick_q;
    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.alarm = alarm_q;

endmodule

// File: tb/tb_slow_tick_timer.sv
// Self-checking bench for slow_tick_timer: tick-timing scoreboard plus a table of countdown
// scenarios and hand-written pause/reset sequences. Expectations follow AUTO_RELOAD_EN if defined.
module tb_slow_tick_timer;

    localparam int CNT_W       = 8;
    localparam int SYNC_STAGES = 2;

    typedef struct {
        logic             start;
        logic             pause;
        logic             clear;
        logic [CNT_W-1:0] load_val;
        int               n_ticks;
        logic [CNT_W-1:0] exp_count;
        logic             exp_busy;
        logic             exp_alarm;
        int               exp_dones;
    } vec_t;

    logic CLOCK    = 1'b0;
    logic RESET_N  = 1'b0;
    logic slow_clk = 1'b0;
    logic slow_en  = 1'b0;
    logic done_prev = 1'b0;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   exp_tick_q[$];
    vec_t vecs[$];

    slow_tick_timer_if #(.CNT_W(CNT_W)) bus ();

    slow_tick_timer #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) dut (
        .CLOCK    (CLOCK),
        .RESET_N  (RESET_N),
        .slow_clk (slow_clk),
        .bus      (bus)
    );

    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Counts n ticks from the current negedge, then steps one more edge so their effect is visible.
    task automatic wait_ticks(input int n);
        int seen   = 0;
        int budget = 30 * n + 30;
        while (seen < n && budget > 0) begin
            if (bus.tick) seen++;
            @(negedge CLOCK);
            budget--;
        end
        if (seen < n) check("tick_timeout", seen, n);
    endtask

    function automatic void add(input logic st, input logic pa, input logic cl,
                                input logic [CNT_W-1:0] lv, input int nt,
                                input logic [CNT_W-1:0] ec, input logic eb,
                                input logic ea, input int ed);
        vec_t v;
        v.start = st; v.pause = pa; v.clear = cl; v.load_val = lv; v.n_ticks = nt;
        v.exp_count = ec; v.exp_busy = eb; v.exp_alarm = ea; v.exp_dones = ed;
        vecs.push_back(v);
    endfunction

    // Slow clock: 20 CLOCK cycles per period; a rise at negedge c is first sampled at posedge
    // c+1 (edge k), so the tick must be visible at the negedge where cyc == k+2 == c+3.
    initial begin : slow_gen
        int phase;
        phase = 0;
        forever begin
            @(negedge CLOCK);
            if (slow_en) begin
                if (phase == 0) begin
                    slow_clk = 1'b1;
                    exp_tick_q.push_back(cyc + 3);
                end else if (phase == 10) begin
                    slow_clk = 1'b0;
                end
                phase = (phase + 1) % 20;
            end else begin
                phase = 0;
            end
        end
    end

    always @(negedge CLOCK) begin
        if (RESET_N) begin
            if (bus.tick) begin
                if (exp_tick_q.size() == 0) check("tick_unexpected", 1, 0);
                else check("tick_cycle", cyc, exp_tick_q.pop_front());
            end else if (exp_tick_q.size() != 0 && exp_tick_q[0] < cyc) begin
                check("tick_missing", cyc, exp_tick_q.pop_front());
            end
            if (bus.done) begin
                check("done_single_cycle", done_prev, 0);
                done_cnt++;
            end
            done_prev = bus.done;
        end else begin
            done_prev = 1'b0;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bus.start = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0; bus.load_val = '0;

        // Reset state
        repeat (3) @(negedge CLOCK);
        check("rst_tick",  bus.tick,  0);
        check("rst_count", bus.count, 0);
        check("rst_busy",  bus.busy,  0);
        check("rst_done",  bus.done,  0);
        check("rst_alarm", bus.alarm, 0);
        RESET_N = 1'b1;
        #1 slow_en = 1'b1;

`ifdef AUTO_RELOAD_EN
        //   st    pa    cl    load  nt  count busy  alarm dones
        add(1'b1, 1'b0, 1'b0, 8'd2, 0, 8'd2, 1'b1, 1'b0, 0);
        add(1'b0, 1'b0, 1'b0, 8'd2, 1, 8'd1, 1'b1, 1'b0, 0);
        add(1'b0, 1'b0, 1'b0, 8'd2, 1, 8'd2, 1'b1, 1'b0, 1);
        add(1'b0, 1'b0, 1'b0, 8'd2, 1, 8'd1, 1'b1, 1'b0, 1);
        add(1'b0, 1'b0, 1'b0, 8'd2, 1, 8'd2, 1'b1, 1'b0, 2);
        add(1'b0, 1'b0, 1'b1, 8'd2, 0, 8'd0, 1'b0, 1'b0, 2);
        add(1'b1, 1'b0, 1'b0, 8'd0, 0, 8'd0, 1'b0, 1'b0, 3);
        add(1'b0, 1'b0, 1'b0, 8'd0, 1, 8'd0, 1'b0, 1'b1, 3);
        add(1'b0, 1'b0, 1'b1, 8'd0, 0, 8'd0, 1'b0, 1'b0, 3);
`else
        //   st    pa    cl    load    nt  count   busy  alarm dones
        add(1'b1, 1'b0, 1'b0, 8'd3,   0, 8'd3,   1'b1, 1'b0, 0);
        add(1'b0, 1'b0, 1'b0, 8'd3,   1, 8'd2,   1'b1, 1'b0, 0);
        add(1'b0, 1'b0, 1'b0, 8'd3,   1, 8'd1,   1'b1, 1'b0, 0);
        add(1'b0, 1'b0, 1'b0, 8'd3,   1, 8'd0,   1'b0, 1'b0, 1);
        add(1'b0, 1'b0, 1'b0, 8'd3,   1, 8'd0,   1'b0, 1'b1, 1);
        add(1'b0, 1'b0, 1'b0, 8'd3,   1, 8'd0,   1'b0, 1'b0, 1);
        add(1'b0, 1'b0, 1'b0, 8'd3,   1, 8'd0,   1'b0, 1'b1, 1);
        add(1'b0, 1'b0, 1'b0, 8'd3,   1, 8'd0,   1'b0, 1'b0, 1);
        add(1'b0, 1'b0, 1'b1, 8'd3,   0, 8'd0,   1'b0, 1'b0, 1);
        add(1'b1, 1'b0, 1'b0, 8'd5,   0, 8'd5,   1'b1, 1'b0, 1);
        add(1'b0, 1'b1, 1'b0, 8'd5,   3, 8'd5,   1'b1, 1'b0, 1);
        add(1'b1, 1'b0, 1'b0, 8'd5,   0, 8'd5,   1'b1, 1'b0, 1);
        add(1'b0, 1'b0, 1'b0, 8'd5,   1, 8'd4,   1'b1, 1'b0, 1);
        add(1'b1, 1'b0, 1'b0, 8'd200, 2, 8'd2,   1'b1, 1'b0, 1);
        add(1'b0, 1'b0, 1'b1, 8'd0,   0, 8'd0,   1'b0, 1'b0, 1);
        add(1'b1, 1'b0, 1'b0, 8'd0,   0, 8'd0,   1'b0, 1'b0, 2);
        add(1'b0, 1'b0, 1'b0, 8'd0,   1, 8'd0,   1'b0, 1'b1, 2);
        add(1'b1, 1'b0, 1'b0, 8'd2,   0, 8'd2,   1'b1, 1'b0, 2);
        add(1'b0, 1'b0, 1'b0, 8'd2,   2, 8'd0,   1'b0, 1'b0, 3);
        add(1'b0, 1'b0, 1'b0, 8'd2,   1, 8'd0,   1'b0, 1'b1, 3);
        add(1'b0, 1'b0, 1'b1, 8'd2,   0, 8'd0,   1'b0, 1'b0, 3);
`endif

        // Align just after an (ignored) IDLE tick so each row starts far from the next tick.
        @(negedge CLOCK);
        wait_ticks(1);
        done_cnt = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.start    = vecs[i].start;
            bus.pause    = vecs[i].pause;
            bus.clear    = vecs[i].clear;
            bus.load_val = vecs[i].load_val;
            @(negedge CLOCK);
            bus.start = 1'b0;
            bus.clear = 1'b0;
            wait_ticks(vecs[i].n_ticks);
            #1;
            check($sformatf("row%0d_count", i), bus.count, vecs[i].exp_count);
            check($sformatf("row%0d_busy",  i), bus.busy,  vecs[i].exp_busy);
            check($sformatf("row%0d_alarm", i), bus.alarm, vecs[i].exp_alarm);
            check($sformatf("row%0d_dones", i), done_cnt,  vecs[i].exp_dones);
        end
        bus.pause = 1'b0;

        // Pause asserted in the very cycle a tick reaches the FSM: the tick is lost.
        bus.load_val = 8'd9;
        bus.start    = 1'b1;
        @(negedge CLOCK);
        bus.start = 1'b0;
        begin : align_tick
            int b;
            b = 40;
            while (!bus.tick && b > 0) begin
                @(negedge CLOCK);
                b--;
            end
            if (!bus.tick) check("pause_align_timeout", 0, 1);
        end
        bus.pause = 1'b1;
        @(negedge CLOCK);
        #1;
        check("pause_tick_count", bus.count, 9);
        check("pause_tick_busy",  bus.busy,  1);
        wait_ticks(1);
        #1;
        check("paused_hold_count", bus.count, 9);
        bus.pause = 1'b0;
        bus.clear = 1'b1;
        @(negedge CLOCK);
        bus.clear = 1'b0;
        #1;
        check("pause_clear_busy",  bus.busy,  0);
        check("pause_clear_count", bus.count, 0);

        // Reset mid-RUN aborts at once; slow_clk high at release counts as an edge.
        bus.load_val = 8'd7;
        bus.start    = 1'b1;
        @(negedge CLOCK);
        bus.start = 1'b0;
        #1;
        check("prereset_count", bus.count, 7);
        slow_en  = 1'b0;
        slow_clk = 1'b0;
        repeat (6) @(negedge CLOCK);
        check("tick_queue_before_reset", exp_tick_q.size(), 0);
        #2 RESET_N = 1'b0;
        #1;
        check("midrst_count", bus.count, 0);
        check("midrst_busy",  bus.busy,  0);
        check("midrst_done",  bus.done,  0);
        check("midrst_alarm", bus.alarm, 0);
        check("midrst_tick",  bus.tick,  0);
        repeat (3) @(negedge CLOCK);
        slow_clk = 1'b1;
        @(negedge CLOCK);
        RESET_N = 1'b1;
        exp_tick_q.push_back(cyc + 3);
        #1;
        check("postrst_count", bus.count, 0);
        check("postrst_busy",  bus.busy,  0);
        @(negedge CLOCK);
        wait_ticks(1);
        #1;
        check("postrst_no_resume", bus.count, 0);
        slow_clk = 1'b0;
        repeat (6) @(negedge CLOCK);
        check("tick_queue_drained", exp_tick_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
